// File: rtl/alu_sequencer.sv
// Operation sequencer in front of ALU_16bit: a request/response handshake wrapped
// around single-pass ALU ops, SLT built on one subtract, and a shift-add MUL on the ALU adder.
module alu_sequencer #(
  parameter int WIDTH     = 16,
  parameter int MUL_STEPS = 16
) (
  input  logic             Clock,
  input  logic             ResetN,
  input  logic             ReqValid,
  output logic             ReqReady,
  input  logic [2:0]       ReqOp,
  input  logic [WIDTH-1:0] ReqA,
  input  logic [WIDTH-1:0] ReqB,
  output logic [WIDTH-1:0] AluA,
  output logic [WIDTH-1:0] AluB,
  output logic [1:0]       ALUOp,
  output logic             BNegate,
  input  logic [WIDTH-1:0] AluResult,
  input  logic             AluZero,
  input  logic             AluCarryOut,
  output logic             RspValid,
  input  logic             RspReady,
  output logic [WIDTH-1:0] RspResult,
  output logic             RspZero,
  output logic             RspCarry
);

  typedef enum logic [1:0] {IDLE, EXEC, MUL, RESP} state_t;
  typedef enum logic [2:0] {
    OP_AND, OP_OR, OP_ADD, OP_SUB, OP_XOR, OP_SLT, OP_MUL, OP_RSVD
  } op_t;

  localparam int SW = (MUL_STEPS > 1) ? $clog2(MUL_STEPS) : 1;
  localparam logic [SW-1:0] STEP_LAST = SW'(MUL_STEPS - 1);

  state_t           state_q, state_d;
  op_t              op_q;
  logic [WIDTH-1:0] a_q, b_q, acc_q, acc_d;
  logic [SW-1:0]    step_q;
  logic [WIDTH-1:0] rsp_result_q;
  logic             rsp_zero_q, rsp_carry_q;
  logic             slt_lt;

  assign ReqReady  = (state_q == IDLE);
  assign RspValid  = (state_q == RESP);
  assign RspResult = rsp_result_q;
  assign RspZero   = rsp_zero_q;
  assign RspCarry  = rsp_carry_q;

  // Signs differ: A's sign decides; otherwise the sign of A-B does (no overflow possible).
  assign slt_lt = (a_q[WIDTH-1] != b_q[WIDTH-1]) ? a_q[WIDTH-1] : AluResult[WIDTH-1];
  // During MUL, a_q holds the shifted multiplicand and b_q the shifted multiplier.
  assign acc_d  = b_q[0] ? AluResult : acc_q;

  always_comb begin
    state_d = state_q;
    AluA    = '0;
    AluB    = '0;
    ALUOp   = 2'b00;
    BNegate = 1'b0;
    case (state_q)
      IDLE: begin
        if (ReqValid) state_d = (op_t'(ReqOp) == OP_MUL) ? MUL : EXEC;
      end
      EXEC: begin
        state_d = RESP;
        AluA    = a_q;
        AluB    = b_q;
        case (op_q)
          OP_AND: ALUOp = 2'b00;
          OP_OR:  ALUOp = 2'b01;
          OP_ADD: ALUOp = 2'b10;
          OP_SUB, OP_SLT: begin
            ALUOp   = 2'b10;
            BNegate = 1'b1;
          end
          OP_XOR: ALUOp = 2'b11;
          default: begin
            AluA = '0;
            AluB = '0;
          end
        endcase
      end
      MUL: begin
        AluA  = acc_q;
        AluB  = a_q;
        ALUOp = 2'b10;
        if (step_q == STEP_LAST) state_d = RESP;
      end
      RESP: begin
        if (RspReady) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      state_q      <= IDLE;
      op_q         <= OP_AND;
      a_q          <= '0;
      b_q          <= '0;
      acc_q        <= '0;
      step_q       <= '0;
      rsp_result_q <= '0;
      rsp_zero_q   <= 1'b0;
      rsp_carry_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (ReqValid) begin
            op_q   <= op_t'(ReqOp);
            a_q    <= ReqA;
            b_q    <= ReqB;
            acc_q  <= '0;
            step_q <= '0;
          end
        end
        EXEC: begin
          case (op_q)
            OP_AND, OP_OR, OP_XOR: begin
              rsp_result_q <= AluResult;
              rsp_zero_q   <= AluZero;
              rsp_carry_q  <= 1'b0;
            end
            OP_ADD, OP_SUB: begin
              rsp_result_q <= AluResult;
              rsp_zero_q   <= AluZero;
              rsp_carry_q  <= AluCarryOut;
            end
            OP_SLT: begin
              rsp_result_q <= {{(WIDTH-1){1'b0}}, slt_lt};
              rsp_zero_q   <= ~slt_lt;
              rsp_carry_q  <= 1'b0;
            end
            default: begin
              rsp_result_q <= '0;
              rsp_zero_q   <= 1'b1;
              rsp_carry_q  <= 1'b0;
            end
          endcase
        end
        MUL: begin
          acc_q  <= acc_d;
          a_q    <= a_q << 1;
          b_q    <= b_q >> 1;
          step_q <= step_q + 1'b1;
          if (step_q == STEP_LAST) begin
            rsp_result_q <= acc_d;
            rsp_zero_q   <= (acc_d == '0);
            rsp_carry_q  <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer with a behavioural ALU_16bit attached to its ALU port.
module tb_alu_sequencer;

  localparam int W = 16;

  logic         Clock = 1'b0;
  logic         ResetN = 1'b0;
  logic         ReqValid = 1'b0;
  logic         ReqReady;
  logic [2:0]   ReqOp = 3'd0;
  logic [W-1:0] ReqA = '0, ReqB = '0;
  logic [W-1:0] AluA, AluB, AluResult;
  logic [1:0]   ALUOp;
  logic         BNegate, AluZero, AluCarryOut;
  logic         RspValid;
  logic         RspReady = 1'b0;
  logic [W-1:0] RspResult;
  logic         RspZero, RspCarry;

  int errors = 0;
  int checks = 0;

  alu_sequencer #(.WIDTH(W), .MUL_STEPS(16)) dut (
    .Clock(Clock), .ResetN(ResetN),
    .ReqValid(ReqValid), .ReqReady(ReqReady), .ReqOp(ReqOp), .ReqA(ReqA), .ReqB(ReqB),
    .AluA(AluA), .AluB(AluB), .ALUOp(ALUOp), .BNegate(BNegate),
    .AluResult(AluResult), .AluZero(AluZero), .AluCarryOut(AluCarryOut),
    .RspValid(RspValid), .RspReady(RspReady),
    .RspResult(RspResult), .RspZero(RspZero), .RspCarry(RspCarry)
  );

  always #5 Clock = ~Clock;

  // ALU_16bit model: the adder carry is produced for every ALUOp, as a ripple chain would.
  logic [W-1:0] bop;
  logic [W:0]   sum;
  always_comb begin
    bop = BNegate ? ~AluB : AluB;
    sum = {1'b0, AluA} + {1'b0, bop} + {{W{1'b0}}, BNegate};
    case (ALUOp)
      2'b00:   AluResult = AluA & bop;
      2'b01:   AluResult = AluA | bop;
      2'b10:   AluResult = sum[W-1:0];
      default: AluResult = AluA ^ bop;
    endcase
    AluZero     = (AluResult == '0);
    AluCarryOut = sum[W];
  end

  typedef struct {
    logic [2:0]   op;
    logic [W-1:0] a, b;
    logic [W-1:0] ea, eb;
    logic [1:0]   aluop;
    logic         bneg;
    logic [W-1:0] res;
    logic         z, c;
    int           lat;
  } vec_t;

  vec_t vt[19];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Present a request and return once the accepting edge has passed.
  task automatic issue(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    int waited;
    @(negedge Clock);
    ReqValid = 1'b1;
    ReqOp    = op;
    ReqA     = a;
    ReqB     = b;
    waited   = 0;
    while (!ReqReady && waited < 20) begin
      @(negedge Clock);
      waited++;
    end
    if (!ReqReady) check("req_ready_timeout", 64'(ReqReady), 64'(1));
    @(posedge Clock);
    #1 ReqValid = 1'b0;
  endtask

  // Count negedges after accept until RspValid; EXEC/first-MUL drive checked at the first one.
  task automatic run_vec(input vec_t v);
    int got;
    issue(v.op, v.a, v.b);
    got = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge Clock);
      if (k == 1) begin
        check("drive_a", 64'(AluA), 64'(v.ea));
        check("drive_b", 64'(AluB), 64'(v.eb));
        check("drive_op", 64'({ALUOp, BNegate}), 64'({v.aluop, v.bneg}));
      end
      if (RspValid) begin
        got = k;
        break;
      end
    end
    check("latency", 64'(got), 64'(v.lat));
    check("result", 64'(RspResult), 64'(v.res));
    check("zero_carry", 64'({RspZero, RspCarry}), 64'({v.z, v.c}));
    check("resp_idle_drive", 64'({AluA, AluB, ALUOp, BNegate}), 64'(0));
    check("resp_req_ready", 64'(ReqReady), 64'(0));
    RspReady = 1'b1;
    @(posedge Clock);
    #1 RspReady = 1'b0;
    check("after_hs_valid", 64'(RspValid), 64'(0));
    check("after_hs_ready", 64'(ReqReady), 64'(1));
  endtask

  logic [W-1:0] held;
  logic         saw_rsp;

  initial begin
    //          op     a         b         ea        eb        aluop  bn    res        z     c     lat
    vt[0]  = '{3'd0, 16'd6,    16'd3,    16'd6,    16'd3,    2'b00, 1'b0, 16'd2,    1'b0, 1'b0, 2};
    vt[1]  = '{3'd1, 16'd6,    16'd3,    16'd6,    16'd3,    2'b01, 1'b0, 16'd7,    1'b0, 1'b0, 2};
    vt[2]  = '{3'd4, 16'd5,    16'd5,    16'd5,    16'd5,    2'b11, 1'b0, 16'd0,    1'b1, 1'b0, 2};
    vt[3]  = '{3'd0, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 2'b00, 1'b0, 16'hFFFF, 1'b0, 1'b0, 2};
    vt[4]  = '{3'd2, 16'd10,   16'd40,   16'd10,   16'd40,   2'b10, 1'b0, 16'd50,   1'b0, 1'b0, 2};
    vt[5]  = '{3'd2, 16'hFFFF, 16'd1,    16'hFFFF, 16'd1,    2'b10, 1'b0, 16'd0,    1'b1, 1'b1, 2};
    vt[6]  = '{3'd3, 16'd10,   16'd10,   16'd10,   16'd10,   2'b10, 1'b1, 16'd0,    1'b1, 1'b1, 2};
    vt[7]  = '{3'd3, 16'd30,   16'd40,   16'd30,   16'd40,   2'b10, 1'b1, 16'hFFF6, 1'b0, 1'b0, 2};
    vt[8]  = '{3'd5, 16'hFFFE, 16'd3,    16'hFFFE, 16'd3,    2'b10, 1'b1, 16'd1,    1'b0, 1'b0, 2};
    vt[9]  = '{3'd5, 16'd3,    16'hFFFE, 16'd3,    16'hFFFE, 2'b10, 1'b1, 16'd0,    1'b1, 1'b0, 2};
    vt[10] = '{3'd5, 16'd5,    16'd5,    16'd5,    16'd5,    2'b10, 1'b1, 16'd0,    1'b1, 1'b0, 2};
    vt[11] = '{3'd5, 16'h8000, 16'h7FFF, 16'h8000, 16'h7FFF, 2'b10, 1'b1, 16'd1,    1'b0, 1'b0, 2};
    vt[12] = '{3'd5, 16'd1,    16'd2,    16'd1,    16'd2,    2'b10, 1'b1, 16'd1,    1'b0, 1'b0, 2};
    vt[13] = '{3'd7, 16'h1234, 16'h5678, 16'd0,    16'd0,    2'b00, 1'b0, 16'd0,    1'b1, 1'b0, 2};
    vt[14] = '{3'd6, 16'd300,  16'd7,    16'd0,    16'd300,  2'b10, 1'b0, 16'd2100, 1'b0, 1'b0, 17};
    vt[15] = '{3'd6, 16'h0100, 16'h0100, 16'd0,    16'h0100, 2'b10, 1'b0, 16'd0,    1'b1, 1'b0, 17};
    vt[16] = '{3'd6, 16'd0,    16'd123,  16'd0,    16'd0,    2'b10, 1'b0, 16'd0,    1'b1, 1'b0, 17};
    vt[17] = '{3'd6, 16'hFFFF, 16'hFFFF, 16'd0,    16'hFFFF, 2'b10, 1'b0, 16'd1,    1'b0, 1'b0, 17};
    vt[18] = '{3'd6, 16'h1234, 16'd5,    16'd0,    16'h1234, 2'b10, 1'b0, 16'h5B04, 1'b0, 1'b0, 17};

    #1;
    check("rst_rsp_valid", 64'(RspValid), 64'(0));
    check("rst_req_ready", 64'(ReqReady), 64'(1));
    check("rst_rsp_regs", 64'({RspResult, RspZero, RspCarry}), 64'(0));
    check("rst_drive", 64'({AluA, AluB, ALUOp, BNegate}), 64'(0));
    @(negedge Clock);
    @(negedge Clock);
    ResetN = 1'b1;

    for (int i = 0; i < 19; i++) run_vec(vt[i]);

    // Response stalled for 5 cycles; a request pulse inside the stall must be dropped.
    issue(3'd2, 16'd100, 16'd23);
    saw_rsp = 1'b0;
    for (int k = 0; k < 10 && !saw_rsp; k++) begin
      @(negedge Clock);
      saw_rsp = RspValid;
    end
    check("stall_valid", 64'(saw_rsp), 64'(1));
    held = RspResult;
    check("stall_result", 64'(held), 64'(123));
    for (int k = 0; k < 5; k++) begin
      ReqValid = (k == 2);
      ReqOp    = 3'd0;
      @(negedge Clock);
      check("stall_hold", 64'({RspValid, RspResult, RspZero, RspCarry}), 64'({1'b1, held, 1'b0, 1'b0}));
      check("stall_req_ready", 64'(ReqReady), 64'(0));
    end
    ReqValid = 1'b0;
    RspReady = 1'b1;
    @(posedge Clock);
    #1 RspReady = 1'b0;
    saw_rsp = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge Clock);
      if (RspValid || !ReqReady) saw_rsp = 1'b1;
    end
    check("dropped_req_not_queued", 64'(saw_rsp), 64'(0));

    // Reset asserted during MUL step 7 aborts the multiply without a response.
    issue(3'd6, 16'd300, 16'd7);
    for (int k = 1; k <= 8; k++) @(negedge Clock);
    check("pre_abort_drive_b", 64'(AluB), 64'(16'd300 << 7));
    ResetN = 1'b0;
    #1;
    check("abort_rsp_valid", 64'(RspValid), 64'(0));
    check("abort_drive", 64'({AluA, AluB, ALUOp, BNegate}), 64'(0));
    check("abort_req_ready", 64'(ReqReady), 64'(1));
    check("abort_rsp_regs", 64'({RspResult, RspZero, RspCarry}), 64'(0));
    @(negedge Clock);
    ResetN = 1'b1;
    saw_rsp = 1'b0;
    for (int k = 0; k < 25; k++) begin
      @(negedge Clock);
      if (RspValid) saw_rsp = 1'b1;
    end
    check("abort_no_response", 64'(saw_rsp), 64'(0));
    run_vec(vt[4]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
